dac_ctrl: RTL
=============

Name: dac_ctrl

Overview:
SPI-style serial transmitter driving an external 8/10/12-bit serial DAC (16-bit frame, SYNC-framed, data latched by the DAC on SCLK falling edge). It is the write-direction counterpart of the ADC serial capture block and sits between board control logic and the DAC pins. It accepts one sample per handshake, serialises it MSB first and reports completion.

Parameters:
CLK_DIV, 2, clk cycles per SCLK half-period; legal range 1..255.
DATA_W, 8, DAC resolution; legal values 8, 10, 12.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
dacEn  in  1  write request; accepted only when ready=1
dacData  in  DATA_W  sample to send; sampled on the accept edge
pdMode  in  2  DAC power-down bits; sampled on the accept edge
ready  out  1  high when idle and able to accept dacEn
done  out  1  one-cycle pulse at frame completion
lastWord  out  16  last frame fully transmitted
cs  out  1  DAC SYNC, active low
sclk  out  1  serial clock, idles high
sdi  out  1  serial data to DAC

Behaviour:
- Frame = {2'b00, pdMode, dacData, (12-DATA_W) zeros}, 16 bits, sent MSB first.
- Reset values (async, immediate): cs=1, sclk=1, sdi=0, ready=1, done=0, lastWord=16'h0000, state IDLE, all counters 0.
- Accept: rising clk edge T with dacEn=1 and ready=1 latches the frame into the shift register. dacEn while ready=0 is ignored; there is no queue.
- States: IDLE -> SHIFT -> HOLD -> GAP -> IDLE.
- SHIFT:
  - At T+1: cs=0, sdi=frame[15], sclk=1, ready=0.
  - sclk is driven high for CLK_DIV cycles, then low for CLK_DIV cycles, for each of 16 bits.
  - The falling edge for bit k (k=0..15, from MSB) occurs at T+1+(2k+1)*CLK_DIV.
  - sdi shifts to the next bit on the same cycle sclk returns high, so it is stable across every falling edge.
  - A 4-bit bit counter advances on each rising return.
- HOLD: after the 16th low half, sclk=1 and cs stays 0 for CLK_DIV cycles.
- cs rises at T+1+33*CLK_DIV. sdi is driven 0 whenever cs=1.
- GAP: cs=1 for CLK_DIV cycles (minimum SYNC-high time).
- Completion: at T+1+34*CLK_DIV, done=1 for one cycle, ready=1, lastWord=frame. Return to IDLE.
- Back-to-back: dacEn held high is accepted on the same cycle ready returns, so the next cs fall is at +1.
- Frame period is 34*CLK_DIV+1 clk cycles.
- Reset mid-frame: cs goes 1 asynchronously; the DAC discards the truncated frame. lastWord is not updated. After rst_n deasserts, the block idles with no spurious sclk edge.
- Divider counter is 8 bits. It reloads to CLK_DIV-1 on every phase change and holds 0 in IDLE.
- done and ready are never both low in IDLE. done never asserts without a full 16-edge frame.

Decomposition:
- Shared package:
  - FRAME_W=16.
  - pdMode encodings: PD_NORMAL=2'b00, PD_1K=2'b01, PD_100K=2'b10, PD_TRI=2'b11.
  - State enum {IDLE, SHIFT, HOLD, GAP}.
- Sub-module dac_clk_tick: half-period tick generator with enable and synchronous restart, parameterised by CLK_DIV.
- Frame assembly and shifting stay in dac_ctrl.

Test Plan:
- Reset release, no dacEn -> cs=1, sclk=1, sdi=0, ready=1, done=0, lastWord=16'h0000 held for 200 cycles.
- CLK_DIV=2, DATA_W=8, pdMode=0, dacData=8'hA5 at T:
  - cs=0 over T+1..T+66.
  - 16 sclk falling edges at T+3+4k; bits sampled on those edges = 16'h0A50.
  - cs high at T+67; done pulse and ready=1 at T+69; lastWord=16'h0A50.
- dacEn pulsed again at T+10 during that frame -> ignored; exactly 16 falling edges; one done.
- dacEn held high, data 8'h01 then 8'hFF, CLK_DIV=1 -> frames 16'h0010 and 16'h0FF0; second cs fall 1 cycle after the first done; period 35 cycles.
- DATA_W=12, pdMode=2'b11, dacData=12'hFFF -> frame 16'h3FFF.
- rst_n low at the 7th falling edge -> cs=1 asynchronously; no done; lastWord unchanged. Next request produces a clean full frame.

Source files
------------

// File: rtl/dac_ctrl_pkg.sv
// Shared definitions for the serial DAC write path: frame width,
// power-down encodings and the transmit state machine states.
package dac_ctrl_pkg;

   localparam int FRAME_W = 16;

   localparam logic [1:0] PD_NORMAL = 2'b00;
   localparam logic [1:0] PD_1K     = 2'b01;
   localparam logic [1:0] PD_100K   = 2'b10;
   localparam logic [1:0] PD_TRI    = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2,
      GAP   = 2'd3
   } state_t;

endpackage

// File: rtl/dac_clk_tick.sv
// Half-period tick generator: fires every CLK_DIV enabled cycles,
// restarts a full half-period on i_restart and parks at zero while disabled.
module dac_clk_tick #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_en,
   input  logic i_restart,
   output logic o_tick
);

   localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

   logic [7:0] r_cnt;

   assign o_tick = i_en && (r_cnt == 8'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= 8'd0;
      end else if (i_restart) begin
         r_cnt <= RELOAD;
      end else if (!i_en) begin
         r_cnt <= 8'd0;
      end else if (r_cnt == 8'd0) begin
         r_cnt <= RELOAD;
      end else begin
         r_cnt <= r_cnt - 8'd1;
      end
   end

endmodule

// File: rtl/dac_ctrl.sv
// SPI-style serial DAC transmitter: accepts one sample per handshake,
// sends a 16-bit SYNC-framed word MSB first and pulses done on completion.
module dac_ctrl
   import dac_ctrl_pkg::*;
#(
   parameter int CLK_DIV = 2,
   parameter int DATA_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              dacEn,
   input  logic [DATA_W-1:0] dacData,
   input  logic [1:0]        pdMode,
   output logic              ready,
   output logic              done,
   output logic [15:0]       lastWord,
   output logic              cs,
   output logic              sclk,
   output logic              sdi
);

   localparam int PAD = 12 - DATA_W;

   state_t             r_state;
   logic               r_load;
   logic [FRAME_W-1:0] r_shreg;
   logic [FRAME_W-1:0] r_frame;
   logic [3:0]         r_bitcnt;
   logic               r_cs;
   logic               r_sclk;
   logic               r_sdi;
   logic               r_ready;
   logic               r_done;
   logic [FRAME_W-1:0] r_lastWord;

   logic               w_tick;
   logic               w_gap_end;
   logic               w_acc;
   logic [FRAME_W-1:0] w_frame;

   // Low-resolution parts pad the sample with zeros below the LSB.
   assign w_frame   = FRAME_W'({2'b00, pdMode, dacData}) << PAD;
   assign w_gap_end = (r_state == GAP) && w_tick;
   // Accepting on the gap's last cycle lets held dacEn chain frames gap-free.
   assign w_acc     = dacEn && (r_ready || w_gap_end);

   dac_clk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_en      ((r_state != IDLE) && !r_load),
      .i_restart (r_load),
      .o_tick    (w_tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_load     <= 1'b0;
         r_shreg    <= '0;
         r_frame    <= '0;
         r_bitcnt   <= 4'd0;
         r_cs       <= 1'b1;
         r_sclk     <= 1'b1;
         r_sdi      <= 1'b0;
         r_ready    <= 1'b1;
         r_done     <= 1'b0;
         r_lastWord <= '0;
      end else begin
         r_done <= 1'b0;
         if (w_acc) begin
            r_shreg <= w_frame;
            r_frame <= w_frame;
            r_load  <= 1'b1;
            r_ready <= 1'b0;
         end
         case (r_state)
            IDLE: begin
               if (w_acc) r_state <= SHIFT;
            end
            SHIFT: begin
               if (r_load) begin
                  r_load   <= 1'b0;
                  r_cs     <= 1'b0;
                  r_sclk   <= 1'b1;
                  r_sdi    <= r_shreg[FRAME_W-1];
                  r_bitcnt <= 4'd0;
               end else if (w_tick) begin
                  if (r_sclk) begin
                     r_sclk <= 1'b0;
                  end else begin
                     // sdi moves only as sclk rises, so it is stable at the fall
                     r_sclk <= 1'b1;
                     if (r_bitcnt == 4'd15) begin
                        r_state <= HOLD;
                     end else begin
                        r_bitcnt <= r_bitcnt + 4'd1;
                        r_shreg  <= {r_shreg[FRAME_W-2:0], 1'b0};
                        r_sdi    <= r_shreg[FRAME_W-2];
                     end
                  end
               end
            end
            HOLD: begin
               if (w_tick) begin
                  r_cs    <= 1'b1;
                  r_sdi   <= 1'b0;
                  r_state <= GAP;
               end
            end
            GAP: begin
               if (w_tick) begin
                  r_done     <= 1'b1;
                  r_lastWord <= r_frame;
                  r_ready    <= !w_acc;
                  r_bitcnt   <= 4'd0;
                  r_state    <= w_acc ? SHIFT : IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign ready    = r_ready;
   assign done     = r_done;
   assign lastWord = r_lastWord;
   assign cs       = r_cs;
   assign sclk     = r_sclk;
   assign sdi      = r_sdi;

endmodule
